// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: FSM state encodings and the
// instruction-word byte stride.
package pc_sequencer_pkg;

    localparam int unsigned INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_STALL = 2'd2
    } state_e;

endpackage

// File: rtl/pc_sequencer_add_four.sv
// Combinational incrementer: adds one instruction-word stride, modulo 2^SIZE.
module add_Four
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned SIZE = 64
) (
    input  logic [SIZE-1:0] in_val,
    output logic [SIZE-1:0] out_val
);

    assign out_val = in_val + SIZE'(INSTR_BYTES);

endmodule

// File: rtl/pc_sequencer.sv
// Instruction-fetch PC sequencer: issues word-aligned fetch requests, tracks
// redirects around outstanding fetches and reports completed fetches.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned    SIZE     = 64,
    parameter logic [SIZE-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [SIZE-1:0] redirect_pc,
    output logic            imem_req,
    output logic [SIZE-1:0] imem_addr,
    input  logic            imem_ack,
    output logic            fetch_valid,
    output logic [SIZE-1:0] fetch_pc,
    output logic [SIZE-1:0] fetch_pc4
);

    localparam logic [SIZE-1:0] ALIGN_MASK  = ~SIZE'(INSTR_BYTES - 1);
    localparam logic [SIZE-1:0] RESET_PC_AL = RESET_PC & ALIGN_MASK;

    state_e          state_q, state_d;
    logic [SIZE-1:0] pc_q, pc_d;
    logic            pend_q, pend_d;
    logic [SIZE-1:0] pend_pc_q, pend_pc_d;
    logic            req_q, req_d;
    logic            fetch_valid_q, fetch_valid_d;
    logic [SIZE-1:0] fetch_pc_q, fetch_pc_d;
    logic [SIZE-1:0] fetch_pc4_q, fetch_pc4_d;

    logic [SIZE-1:0] pc_inc;
    logic [SIZE-1:0] link_inc;
    logic [SIZE-1:0] redirect_al;

    assign redirect_al = redirect_pc & ALIGN_MASK;

    add_Four #(.SIZE(SIZE)) u_pc_inc (
        .in_val  (pc_q),
        .out_val (pc_inc)
    );

    add_Four #(.SIZE(SIZE)) u_link_inc (
        .in_val  (pc_q),
        .out_val (link_inc)
    );

    // Next-state, PC update and completion reporting
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_d        = pend_q;
        pend_pc_d     = pend_pc_q;
        fetch_valid_d = 1'b0;
        fetch_pc_d    = fetch_pc_q;
        fetch_pc4_d   = fetch_pc4_q;

        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (imem_ack) begin
                    // A same-cycle redirect beats a pending one; either discards the word
                    if (redirect_valid) begin
                        pc_d = redirect_al;
                    end else if (pend_q) begin
                        pc_d = pend_pc_q;
                    end else begin
                        pc_d          = pc_inc;
                        fetch_valid_d = 1'b1;
                        fetch_pc_d    = pc_q;
                        fetch_pc4_d   = link_inc;
                    end
                    pend_d  = 1'b0;
                    state_d = stall ? ST_STALL : ST_REQ;
                end else if (redirect_valid) begin
                    pend_d    = 1'b1;
                    pend_pc_d = redirect_al;
                end
            end
            ST_STALL: begin
                if (redirect_valid) begin
                    pc_d = redirect_al;
                end
                if (!stall) begin
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        req_d = (state_d == ST_REQ);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC_AL;
            pend_q        <= 1'b0;
            pend_pc_q     <= '0;
            req_q         <= 1'b0;
            fetch_valid_q <= 1'b0;
            fetch_pc_q    <= '0;
            fetch_pc4_q   <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_q        <= pend_d;
            pend_pc_q     <= pend_pc_d;
            req_q         <= req_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_pc_q    <= fetch_pc_d;
            fetch_pc4_q   <= fetch_pc4_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign fetch_valid = fetch_valid_q;
    assign fetch_pc    = fetch_pc_q;
    assign fetch_pc4   = fetch_pc4_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a per-cycle vector table plus hand-written
// reset sequences, including a second instance that wraps at the top of memory.
module tb_pc_sequencer;

    localparam int unsigned SIZE = 64;

    typedef struct {
        logic            stall;
        logic            rv;
        logic [SIZE-1:0] rpc;
        logic            ack;
        logic            req;
        logic [SIZE-1:0] addr;
        logic            fv;
        logic [SIZE-1:0] fpc;
        logic [SIZE-1:0] fpc4;
    } vec_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            stall = 1'b0;
    logic            redirect_valid = 1'b0;
    logic [SIZE-1:0] redirect_pc = '0;
    logic            imem_ack = 1'b0;
    logic            imem_req;
    logic [SIZE-1:0] imem_addr;
    logic            fetch_valid;
    logic [SIZE-1:0] fetch_pc;
    logic [SIZE-1:0] fetch_pc4;

    logic            reset2 = 1'b1;
    logic            imem_req2;
    logic [SIZE-1:0] imem_addr2;
    logic            fetch_valid2;
    logic [SIZE-1:0] fetch_pc2;
    logic [SIZE-1:0] fetch_pc42;

    int checks = 0;
    int errors = 0;

    vec_t vecs[$];

    always #5 clk = ~clk;

    pc_sequencer #(.SIZE(SIZE), .RESET_PC(64'h1000)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .fetch_valid    (fetch_valid),
        .fetch_pc       (fetch_pc),
        .fetch_pc4      (fetch_pc4)
    );

    pc_sequencer #(.SIZE(SIZE), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (
        .clk            (clk),
        .reset          (reset2),
        .stall          (1'b0),
        .redirect_valid (1'b0),
        .redirect_pc    (64'h0),
        .imem_req       (imem_req2),
        .imem_addr      (imem_addr2),
        .imem_ack       (1'b1),
        .fetch_valid    (fetch_valid2),
        .fetch_pc       (fetch_pc2),
        .fetch_pc4      (fetch_pc42)
    );

    task automatic chk(input string name, input logic [SIZE-1:0] act, input logic [SIZE-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic s, input logic rv, input logic [SIZE-1:0] rpc, input logic ack,
                           input logic req, input logic [SIZE-1:0] addr, input logic fv,
                           input logic [SIZE-1:0] fpc, input logic [SIZE-1:0] fpc4);
        vec_t v;
        v.stall = s; v.rv = rv; v.rpc = rpc; v.ack = ack;
        v.req = req; v.addr = addr; v.fv = fv; v.fpc = fpc; v.fpc4 = fpc4;
        vecs.push_back(v);
    endtask

    initial begin
        // stall rv rpc ack | req addr fv fpc fpc4   (outputs after the edge)
        add_vec(0, 0, 64'h0,    0, 1, 64'h1000, 0, 64'h0,    64'h0);
        add_vec(0, 0, 64'h0,    1, 1, 64'h1004, 1, 64'h1000, 64'h1004);
        add_vec(0, 0, 64'h0,    1, 1, 64'h1008, 1, 64'h1004, 64'h1008);
        add_vec(0, 0, 64'h0,    1, 1, 64'h100C, 1, 64'h1008, 64'h100C);
        add_vec(0, 0, 64'h0,    0, 1, 64'h100C, 0, 64'h1008, 64'h100C);
        // redirect while waiting: latched, address held, word discarded
        add_vec(0, 1, 64'h8002, 0, 1, 64'h100C, 0, 64'h1008, 64'h100C);
        add_vec(1, 0, 64'h0,    0, 1, 64'h100C, 0, 64'h1008, 64'h100C);
        add_vec(0, 0, 64'h0,    1, 1, 64'h8000, 0, 64'h1008, 64'h100C);
        // same-cycle redirect with ack
        add_vec(0, 1, 64'h40,   1, 1, 64'h40,   0, 64'h1008, 64'h100C);
        // ack with stall -> STALL, redirect inside stall, then resume
        add_vec(1, 0, 64'h0,    1, 0, 64'h44,   1, 64'h40,   64'h44);
        add_vec(1, 0, 64'h0,    1, 0, 64'h44,   0, 64'h40,   64'h44);
        add_vec(1, 1, 64'h5003, 0, 0, 64'h5000, 0, 64'h40,   64'h44);
        add_vec(0, 0, 64'h0,    0, 1, 64'h5000, 0, 64'h40,   64'h44);
        add_vec(0, 0, 64'h0,    1, 1, 64'h5004, 1, 64'h5000, 64'h5004);
        // later pending redirect overwrites earlier one
        add_vec(0, 1, 64'h100,  0, 1, 64'h5004, 0, 64'h5000, 64'h5004);
        add_vec(0, 1, 64'h200,  0, 1, 64'h5004, 0, 64'h5000, 64'h5004);
        add_vec(0, 0, 64'h0,    1, 1, 64'h200,  0, 64'h5000, 64'h5004);
        add_vec(0, 0, 64'h0,    0, 1, 64'h200,  0, 64'h5000, 64'h5004);
        add_vec(0, 1, 64'h1010, 1, 1, 64'h1010, 0, 64'h5000, 64'h5004);
        add_vec(0, 0, 64'h0,    0, 1, 64'h1010, 0, 64'h5000, 64'h5004);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req",  {63'h0, imem_req},    64'h0);
        chk("rst_addr", imem_addr,            64'h1000);
        chk("rst_fv",   {63'h0, fetch_valid}, 64'h0);
        chk("rst_fpc",  fetch_pc,             64'h0);
        chk("rst_fpc4", fetch_pc4,            64'h0);

        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("idle_req", {63'h0, imem_req}, 64'h0);

        foreach (vecs[i]) begin
            @(negedge clk);
            stall          = vecs[i].stall;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            imem_ack       = vecs[i].ack;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_req", i),  {63'h0, imem_req},    {63'h0, vecs[i].req});
            chk($sformatf("v%0d_addr", i), imem_addr,            vecs[i].addr);
            chk($sformatf("v%0d_fv", i),   {63'h0, fetch_valid}, {63'h0, vecs[i].fv});
            chk($sformatf("v%0d_fpc", i),  fetch_pc,             vecs[i].fpc);
            chk($sformatf("v%0d_fpc4", i), fetch_pc4,            vecs[i].fpc4);
        end

        // reset while waiting for ack at 0x1010: asynchronous, fetch abandoned
        @(negedge clk);
        stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        #2;
        reset    = 1'b1;
        imem_ack = 1'b1;
        #1;
        chk("arst_req",  {63'h0, imem_req},    64'h0);
        chk("arst_addr", imem_addr,            64'h1000);
        chk("arst_fpc",  fetch_pc,             64'h0);
        chk("arst_fpc4", fetch_pc4,            64'h0);
        @(posedge clk);
        #1;
        chk("arst_fv", {63'h0, fetch_valid}, 64'h0);
        @(negedge clk);
        reset    = 1'b0;
        imem_ack = 1'b0;
        @(posedge clk);
        #1;
        chk("restart_req",  {63'h0, imem_req},    64'h1);
        chk("restart_addr", imem_addr,            64'h1000);
        chk("restart_fv",   {63'h0, fetch_valid}, 64'h0);
        @(posedge clk);
        #1;
        chk("restart_fv2",  {63'h0, fetch_valid}, 64'h0);

        // wrap at top of address space, ack tied high
        @(negedge clk);
        reset2 = 1'b0;
        @(posedge clk);
        #1;
        chk("wrap_req",  {63'h0, imem_req2}, 64'h1);
        chk("wrap_addr", imem_addr2,         64'hFFFF_FFFF_FFFF_FFFC);
        @(posedge clk);
        #1;
        chk("wrap_fv",   {63'h0, fetch_valid2}, 64'h1);
        chk("wrap_fpc",  fetch_pc2,             64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_fpc4", fetch_pc42,            64'h0);
        chk("wrap_next", imem_addr2,            64'h0);
        @(posedge clk);
        #1;
        chk("wrap_fpc_b",  fetch_pc2,  64'h0);
        chk("wrap_fpc4_b", fetch_pc42, 64'h4);
        chk("wrap_addr_b", imem_addr2, 64'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
